// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-port SRAM request arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int WDATA_W_DEF = 32;
  localparam int RDATA_W_DEF = 64;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker2.sv
// Two-requester winner selection: round-robin on ties, or fixed priority to port 0.
module rr_picker2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       any_req,
  output logic       winner
);

  always_comb begin
    any_req = |req;
    winner  = 1'b0;
    if (req == 2'b11) begin
      // On a tie, round-robin favours the port that did not complete last.
      winner = FIXED_PRIO ? 1'b0 : ~last_served;
    end else if (req == 2'b10) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller request port between two masters, one transaction at a time,
// with a mandatory idle cycle between grants and a watchdog on stalled grants.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WDATA_W    = WDATA_W_DEF,
  parameter int RDATA_W    = RDATA_W_DEF,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0RdEn,
  input  logic               m0WrEn,
  input  logic [ADDR_W-1:0]  m0Address,
  input  logic [WDATA_W-1:0] m0WriteData,
  output logic [RDATA_W-1:0] m0ReadData,
  output logic               m0Ready,
  input  logic               m1RdEn,
  input  logic               m1WrEn,
  input  logic [ADDR_W-1:0]  m1Address,
  input  logic [WDATA_W-1:0] m1WriteData,
  output logic [RDATA_W-1:0] m1ReadData,
  output logic               m1Ready,
  output logic               sramRdEn,
  output logic               sramWrEn,
  output logic [ADDR_W-1:0]  sramAddress,
  output logic [WDATA_W-1:0] sramWriteData,
  input  logic [RDATA_W-1:0] sramReadData,
  input  logic               sramReady,
  output logic [1:0]         grant,
  output logic               timeout,
  output arb_state_e         state_dbg
);

  // Handshake: a master holds RdEn/WrEn (with stable address/data) until its Ready pulses;
  // Ready is a single-cycle pulse in the cycle sramReady is seen while that port owns the bus.

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  logic            last_served_q, last_served_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic any_req, winner;

  rr_picker2 #(.FIXED_PRIO(FIXED_PRIO)) u_picker (
    .req        ({m1RdEn | m1WrEn, m0RdEn | m0WrEn}),
    .last_served(last_served_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  logic               in_gnt, gnt_port;
  logic               cur_rd, cur_wr, cur_req;
  logic [ADDR_W-1:0]  cur_addr;
  logic [WDATA_W-1:0] cur_wdata;
  logic               done, wd_fire;

  always_comb begin
    in_gnt    = (state_q != ST_IDLE);
    gnt_port  = (state_q == ST_GNT1);
    cur_rd    = gnt_port ? m1RdEn      : m0RdEn;
    cur_wr    = gnt_port ? m1WrEn      : m0WrEn;
    cur_addr  = gnt_port ? m1Address   : m0Address;
    cur_wdata = gnt_port ? m1WriteData : m0WriteData;
    cur_req   = cur_rd | cur_wr;
    done      = in_gnt & cur_req & sramReady;
    wd_fire   = in_gnt & cur_req & ~sramReady & (wdog_q == WD_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_served_q <= 1'b1;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      wdog_q        <= wdog_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    wdog_d        = wdog_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = winner ? ST_GNT1 : ST_GNT0;
          wdog_d  = '0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!cur_req) begin
          state_d = ST_IDLE;
        end else if (done || wd_fire) begin
          state_d       = ST_IDLE;
          last_served_d = gnt_port;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write wins over read if a master illegally raises both.
  always_comb begin
    grant         = {state_q == ST_GNT1, state_q == ST_GNT0};
    sramWrEn      = in_gnt & cur_wr;
    sramRdEn      = in_gnt & cur_rd & ~cur_wr;
    sramAddress   = in_gnt ? cur_addr  : '0;
    sramWriteData = in_gnt ? cur_wdata : '0;
    m0Ready       = done & ~gnt_port;
    m1Ready       = done &  gnt_port;
    m0ReadData    = (m0Ready && !cur_wr) ? sramReadData : '0;
    m1ReadData    = (m1Ready && !cur_wr) ? sramReadData : '0;
    timeout       = wd_fire;
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: round-robin instance plus a fixed-priority instance.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 32, WW = 32, RW = 64;

  logic clk = 1'b0;
  logic rst;
  logic m0RdEn, m0WrEn, m1RdEn, m1WrEn;
  logic [AW-1:0] m0Address, m1Address;
  logic [WW-1:0] m0WriteData, m1WriteData;
  logic [RW-1:0] sramReadData;
  logic sramReady;

  logic [RW-1:0] m0ReadData, m1ReadData;
  logic m0Ready, m1Ready, sramRdEn, sramWrEn, timeout;
  logic [AW-1:0] sramAddress;
  logic [WW-1:0] sramWriteData;
  logic [1:0] grant;
  arb_state_e state_dbg;

  logic [RW-1:0] fp_m0ReadData, fp_m1ReadData;
  logic fp_m0Ready, fp_m1Ready, fp_sramRdEn, fp_sramWrEn, fp_timeout;
  logic [AW-1:0] fp_sramAddress;
  logic [WW-1:0] fp_sramWriteData;
  logic [1:0] fp_grant;
  arb_state_e fp_state_dbg;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0RdEn(m0RdEn), .m0WrEn(m0WrEn), .m0Address(m0Address), .m0WriteData(m0WriteData),
    .m0ReadData(m0ReadData), .m0Ready(m0Ready),
    .m1RdEn(m1RdEn), .m1WrEn(m1WrEn), .m1Address(m1Address), .m1WriteData(m1WriteData),
    .m1ReadData(m1ReadData), .m1Ready(m1Ready),
    .sramRdEn(sramRdEn), .sramWrEn(sramWrEn), .sramAddress(sramAddress),
    .sramWriteData(sramWriteData), .sramReadData(sramReadData), .sramReady(sramReady),
    .grant(grant), .timeout(timeout), .state_dbg(state_dbg)
  );

  sram_port_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst(rst),
    .m0RdEn(m0RdEn), .m0WrEn(m0WrEn), .m0Address(m0Address), .m0WriteData(m0WriteData),
    .m0ReadData(fp_m0ReadData), .m0Ready(fp_m0Ready),
    .m1RdEn(m1RdEn), .m1WrEn(m1WrEn), .m1Address(m1Address), .m1WriteData(m1WriteData),
    .m1ReadData(fp_m1ReadData), .m1Ready(fp_m1Ready),
    .sramRdEn(fp_sramRdEn), .sramWrEn(fp_sramWrEn), .sramAddress(fp_sramAddress),
    .sramWriteData(fp_sramWriteData), .sramReadData(sramReadData), .sramReady(sramReady),
    .grant(fp_grant), .timeout(fp_timeout), .state_dbg(fp_state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0RdEn = 0; m0WrEn = 0; m1RdEn = 0; m1WrEn = 0;
    m0Address = '0; m1Address = '0; m0WriteData = '0; m1WriteData = '0;
    sramReadData = '0; sramReady = 0;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant got %b want 00", grant); end
    vectors++; if (state_dbg !== ST_IDLE) begin miscompares++; $display("FAIL rst_state got %0d want 0", state_dbg); end
    vectors++; if ({sramRdEn, sramWrEn} !== 2'b00) begin miscompares++; $display("FAIL rst_en got %b want 00", {sramRdEn, sramWrEn}); end
    vectors++; if (sramAddress !== '0) begin miscompares++; $display("FAIL rst_addr got %h want 0", sramAddress); end
    vectors++; if (sramWriteData !== '0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", sramWriteData); end
    vectors++; if ({m0Ready, m1Ready, timeout} !== 3'b000) begin miscompares++; $display("FAIL rst_ready got %b want 000", {m0Ready, m1Ready, timeout}); end
    vectors++; if (m0ReadData !== '0 || m1ReadData !== '0) begin miscompares++; $display("FAIL rst_rdata got %h/%h want 0/0", m0ReadData, m1ReadData); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0RdEn = 1; m0Address = 32'h100;
    settle();
    vectors++; if (grant !== 2'b00 || sramRdEn !== 1'b0) begin miscompares++; $display("FAIL rd_req_cycle got grant %b rd %b want 00/0", grant, sramRdEn); end
    tick();
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rd_grant got %b want 01", grant); end
    vectors++; if (sramRdEn !== 1'b1 || sramWrEn !== 1'b0) begin miscompares++; $display("FAIL rd_en got %b%b want 10", sramRdEn, sramWrEn); end
    vectors++; if (sramAddress !== 32'h100) begin miscompares++; $display("FAIL rd_addr got %h want 00000100", sramAddress); end
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++; if (m0Ready !== 1'b0) begin miscompares++; $display("FAIL rd_early_ready cyc %0d got %b want 0", c, m0Ready); end
    end
    tick();
    sramReady = 1; sramReadData = 64'hDEADBEEF_01234567;
    settle();
    vectors++; if (m0Ready !== 1'b1 || m1Ready !== 1'b0) begin miscompares++; $display("FAIL rd_ready got %b%b want 10", m0Ready, m1Ready); end
    vectors++; if (m0ReadData !== 64'hDEADBEEF_01234567) begin miscompares++; $display("FAIL rd_data got %h want deadbeef01234567", m0ReadData); end
    tick();
    m0RdEn = 0; sramReady = 0;
    settle();
    vectors++; if (grant !== 2'b00 || m0Ready !== 1'b0) begin miscompares++; $display("FAIL rd_release got grant %b ready %b want 00/0", grant, m0Ready); end
  endtask

  task automatic test_tie_write_read();
    do_reset();
    m0WrEn = 1; m0Address = 32'h200; m0WriteData = 32'hCAFE_F00D;
    m1RdEn = 1; m1Address = 32'h300;
    tick();
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL tie_first got %b want 01", grant); end
    vectors++; if ({sramWrEn, sramRdEn} !== 2'b10) begin miscompares++; $display("FAIL tie_wr_en got %b want 10", {sramWrEn, sramRdEn}); end
    vectors++; if (sramAddress !== 32'h200 || sramWriteData !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL tie_wr_bus got %h/%h want 00000200/cafef00d", sramAddress, sramWriteData); end
    sramReady = 1; sramReadData = 64'h1111_2222_3333_4444;
    settle();
    vectors++; if ({m1Ready, m0Ready} !== 2'b01) begin miscompares++; $display("FAIL tie_wr_ready got %b want 01", {m1Ready, m0Ready}); end
    vectors++; if (m0ReadData !== '0) begin miscompares++; $display("FAIL tie_wr_rdata got %h want 0", m0ReadData); end
    tick();
    m0WrEn = 0; sramReady = 0;
    settle();
    vectors++; if (grant !== 2'b00 || sramRdEn !== 1'b0 || sramWrEn !== 1'b0) begin miscompares++; $display("FAIL tie_gap got grant %b en %b%b want 00/00", grant, sramRdEn, sramWrEn); end
    tick();
    vectors++; if (grant !== 2'b10 || sramRdEn !== 1'b1 || sramAddress !== 32'h300) begin miscompares++; $display("FAIL tie_second got grant %b rd %b addr %h want 10/1/00000300", grant, sramRdEn, sramAddress); end
    sramReady = 1; sramReadData = 64'h0123_4567_89AB_CDEF;
    settle();
    vectors++; if (m1Ready !== 1'b1 || m1ReadData !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL tie_rd_done got %b/%h want 1/0123456789abcdef", m1Ready, m1ReadData); end
    tick();
    m1RdEn = 0; sramReady = 0;
  endtask

  task automatic test_alternation();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    m0RdEn = 1; m1RdEn = 1; m0Address = 32'h10; m1Address = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (grant !== exp_g[i]) begin miscompares++; $display("FAIL alt_rr txn %0d got %b want %b", i, grant, exp_g[i]); end
      vectors++; if (fp_grant !== 2'b01) begin miscompares++; $display("FAIL alt_fixed txn %0d got %b want 01", i, fp_grant); end
      sramReady = 1;
      settle();
      vectors++; if ({m1Ready, m0Ready} !== exp_g[i]) begin miscompares++; $display("FAIL alt_ready txn %0d got %b want %b", i, {m1Ready, m0Ready}, exp_g[i]); end
      tick();
      sramReady = 0;
      settle();
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL alt_gap txn %0d got %b want 00", i, grant); end
    end
    m0RdEn = 0; m1RdEn = 0;
  endtask

  task automatic test_starvation();
    do_reset();
    m0RdEn = 1;
    tick();
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL starve_m0 got %b want 01", grant); end
    m1RdEn = 1;
    tick();
    sramReady = 1;
    settle();
    vectors++; if (m0Ready !== 1'b1) begin miscompares++; $display("FAIL starve_m0_done got %b want 1", m0Ready); end
    tick();
    sramReady = 0;
    tick();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL starve_m1_turn got %b want 10", grant); end
    sramReady = 1;
    settle();
    vectors++; if (m1Ready !== 1'b1 || m0Ready !== 1'b0) begin miscompares++; $display("FAIL starve_m1_done got %b%b want 10", m1Ready, m0Ready); end
    tick();
    sramReady = 0; m0RdEn = 0; m1RdEn = 0;
  endtask

  task automatic test_abort();
    do_reset();
    m0RdEn = 1;
    tick();
    sramReady = 1;
    tick();
    sramReady = 0; m0RdEn = 0;
    m1RdEn = 1;
    tick();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL abort_grant got %b want 10", grant); end
    tick();
    m1RdEn = 0;
    settle();
    vectors++; if (m1Ready !== 1'b0 || sramRdEn !== 1'b0) begin miscompares++; $display("FAIL abort_no_ready got ready %b rd %b want 0/0", m1Ready, sramRdEn); end
    tick();
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL abort_idle got %b want 00", grant); end
    m0RdEn = 1; m1RdEn = 1;
    tick();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL abort_keeps_last got %b want 10", grant); end
    m0RdEn = 0; m1RdEn = 0;
  endtask

  task automatic test_watchdog();
    do_reset();
    m0RdEn = 1; m0Address = 32'h80;
    for (int c = 1; c <= 8; c++) begin
      tick();
      vectors++; if (timeout !== (c == 8)) begin miscompares++; $display("FAIL wd_pulse cyc %0d got %b want %b", c, timeout, (c == 8)); end
      vectors++; if (m0Ready !== 1'b0 || grant !== 2'b01) begin miscompares++; $display("FAIL wd_hold cyc %0d got ready %b grant %b want 0/01", c, m0Ready, grant); end
    end
    tick();
    m1RdEn = 1;
    settle();
    vectors++; if (grant !== 2'b00 || timeout !== 1'b0) begin miscompares++; $display("FAIL wd_idle got grant %b to %b want 00/0", grant, timeout); end
    tick();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL wd_last_served got %b want 10", grant); end
    m0RdEn = 0; m1RdEn = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0RdEn = 1; m0Address = 32'h44;
    tick();
    vectors++; if (grant !== 2'b01 || sramRdEn !== 1'b1) begin miscompares++; $display("FAIL rmid_pre got grant %b rd %b want 01/1", grant, sramRdEn); end
    rst = 1;
    tick();
    rst = 0; m0RdEn = 0; sramReady = 1; sramReadData = 64'h5555;
    settle();
    vectors++; if (grant !== 2'b00 || sramRdEn !== 1'b0 || sramAddress !== '0) begin miscompares++; $display("FAIL rmid_outputs got grant %b rd %b addr %h want 00/0/0", grant, sramRdEn, sramAddress); end
    vectors++; if ({m0Ready, m1Ready, timeout} !== 3'b000 || m0ReadData !== '0) begin miscompares++; $display("FAIL rmid_stray got %b data %h want 000/0", {m0Ready, m1Ready, timeout}, m0ReadData); end
    tick();
    sramReady = 0;
    settle();
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rmid_stays_idle got %b want 00", grant); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_write_read();
    test_alternation();
    test_starvation();
    test_abort();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
